// File: rtl/fft16_stage_sequencer.sv
// fft16_stage_sequencer
//   Frame controller for a 16-point radix-2 DIT FFT built around an external
//   butterfly_block (8 parallel complex butterflies). A frame is handled in three phases:
//     LOAD    : 16 input samples are written into a register file in
//               bit-reversed order.
//     COMPUTE : 4 stages run. In each stage the operand pairs and twiddles go
//               to the butterfly block, and the results are written back in place.
//     UNLOAD  : the 16 bins are streamed out in natural order.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input sample handshake (in_real, in_imag)
//   bf_in, bf_tw             registered operands / twiddles to butterfly_block
//   bf_out                   butterfly results, BF_LAT cycles after bf_in
//   out_valid/out_ready      output bin handshake (out_real, out_imag, out_last)
//   busy                     high during COMPUTE and UNLOAD
//
// Packing: complex element e sits at [e*2*DATA_W +: 2*DATA_W] as {imag, real}.
//
// Optional build macro FFT_STAGE_SCALE_EN: every write-back is arithmetically
// shifted right by one (floor), so the output is X/16.
module fft16_stage_sequencer #(
    parameter int DATA_W  = 16,
    parameter int BF_LAT  = 0,
    parameter int TW_FRAC = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_real,
    input  logic [DATA_W-1:0]     in_imag,
    output logic [32*DATA_W-1:0]  bf_in,
    output logic [16*DATA_W-1:0]  bf_tw,
    input  logic [32*DATA_W-1:0]  bf_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_real,
    output logic [DATA_W-1:0]     out_imag,
    output logic                  out_last,
    output logic                  busy
);
    localparam int CW = 2 * DATA_W;
    localparam int WW = (BF_LAT > 0) ? $clog2(BF_LAT + 1) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(BF_LAT);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t              state, state_nxt;
    logic [3:0]          ld_cnt, u_cnt;
    logic [1:0]          s_cnt, s_route;
    logic [WW-1:0]       w_cnt;
    logic [CW-1:0]       mem     [16];
    logic [CW-1:0]       mem_nxt [16];
    logic                load_en, wb_en;
    logic [32*DATA_W-1:0] bf_in_nxt;
    logic [16*DATA_W-1:0] bf_tw_nxt;

    function automatic logic [3:0] bitrev4(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

    // Index of the top operand for butterfly b in stage s (h = 2^s).
    function automatic logic [3:0] top_idx(input logic [1:0] s, input logic [2:0] b);
        logic [3:0] p, hi;
        p  = {1'b0, b} & ((4'd1 << s) - 4'd1);
        hi = (({1'b0, b} >> s) << s) << 1;
        return hi + p;
    endfunction

    function automatic logic [3:0] bot_idx(input logic [1:0] s, input logic [2:0] b);
        return top_idx(s, b) + (4'd1 << s);
    endfunction

    // Twiddle exponent k = p * (8 >> s).
    function automatic logic [2:0] k_idx(input logic [1:0] s, input logic [2:0] b);
        logic [3:0] p;
        p = {1'b0, b} & ((4'd1 << s) - 4'd1);
        return 3'(p * (4'd8 >> s));
    endfunction

    // The ROM constants are Q1.14. They are rescaled to TW_FRAC fractional bits.
    function automatic logic [DATA_W-1:0] tw_q(input int c);
        longint v;
        v = (longint'(c) * (longint'(1) << TW_FRAC)) / longint'(16384);
        return DATA_W'(v);
    endfunction

    function automatic logic [CW-1:0] tw_rom(input logic [2:0] k);
        int re, im;
        case (k)
            3'd0: begin re = 16384;  im = 0;      end
            3'd1: begin re = 15137;  im = -6270;  end
            3'd2: begin re = 11585;  im = -11585; end
            3'd3: begin re = 6270;   im = -15137; end
            3'd4: begin re = 0;      im = -16384; end
            3'd5: begin re = -6270;  im = -15137; end
            3'd6: begin re = -11585; im = -11585; end
            default: begin re = -15137; im = -6270; end
        endcase
        return {tw_q(im), tw_q(re)};
    endfunction

    function automatic logic [CW-1:0] wb_val(input logic [CW-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
        return {DATA_W'($signed(v[CW-1:DATA_W]) >>> 1),
                DATA_W'($signed(v[DATA_W-1:0]) >>> 1)};
`else
        return v;
`endif
    endfunction

    assign load_en = (state == S_LOAD) && in_valid;
    assign wb_en   = (state == S_COMPUTE) && (w_cnt == W_LAST);
    // The operand registers are loaded with the stage that runs next cycle.
    assign s_route = wb_en ? s_cnt + 2'd1 : s_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if (in_valid && ld_cnt == 4'd15)   state_nxt = S_COMPUTE;
            S_COMPUTE: if (wb_en && s_cnt == 2'd3)        state_nxt = S_UNLOAD;
            S_UNLOAD:  if (out_ready && u_cnt == 4'd15)   state_nxt = S_LOAD;
            default:                                      state_nxt = S_LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_LOAD:    in_ready = 1'b1;
            S_COMPUTE: busy = 1'b1;
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (u_cnt == 4'd15);
            end
            default: ;
        endcase
    end

    assign out_real = mem[u_cnt][DATA_W-1:0];
    assign out_imag = mem[u_cnt][CW-1:DATA_W];

    // Counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt <= '0;
            s_cnt  <= '0;
            w_cnt  <= '0;
            u_cnt  <= '0;
        end else begin
            if (load_en) ld_cnt <= ld_cnt + 4'd1;
            if (state == S_COMPUTE) begin
                if (wb_en) begin
                    w_cnt <= '0;
                    s_cnt <= s_cnt + 2'd1;
                end else begin
                    w_cnt <= w_cnt + WW'(1);
                end
            end
            if (out_valid && out_ready) u_cnt <= u_cnt + 4'd1;
        end
    end

    // Register-file update. The next-cycle image is formed here so that the
    // operand registers can be loaded straight from the just-written results.
    always_comb begin
        mem_nxt = mem;
        if (!rst) begin
            if (load_en) begin
                mem_nxt[bitrev4(ld_cnt)] = {in_imag, in_real};
            end else if (wb_en) begin
                for (int b = 0; b < 8; b++) begin
                    mem_nxt[top_idx(s_cnt, 3'(b))] = wb_val(bf_out[(2*b)*CW +: CW]);
                    mem_nxt[bot_idx(s_cnt, 3'(b))] = wb_val(bf_out[(2*b+1)*CW +: CW]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem <= mem_nxt;
    end

    // Operand routing for the stage that runs in the next cycle
    always_comb begin
        bf_in_nxt = '0;
        bf_tw_nxt = '0;
        for (int b = 0; b < 8; b++) begin
            bf_in_nxt[(2*b)*CW +: CW]   = mem_nxt[top_idx(s_route, 3'(b))];
            bf_in_nxt[(2*b+1)*CW +: CW] = mem_nxt[bot_idx(s_route, 3'(b))];
            bf_tw_nxt[b*CW +: CW]       = tw_rom(k_idx(s_route, 3'(b)));
        end
    end

    // During a stage the sources stay unchanged until write-back, so these
    // registers hold steady for BF_LAT+1 cycles. They are zero outside COMPUTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            bf_in <= '0;
            bf_tw <= '0;
        end else if (state_nxt == S_COMPUTE) begin
            bf_in <= bf_in_nxt;
            bf_tw <= bf_tw_nxt;
        end else begin
            bf_in <= '0;
            bf_tw <= '0;
        end
    end

endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Testbench for fft16_stage_sequencer with a 2-cycle butterfly model.
// The model can also be switched to passthrough for the routing checks.
module tb_fft16_stage_sequencer;
    localparam int DW  = 16;
    localparam int LAT = 2;
`ifdef FFT_STAGE_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;
    logic in_ready, out_valid, out_last, busy;
    logic [DW-1:0] out_real, out_imag;
    logic [32*DW-1:0] bf_in, bf_out, bf_comb, pipe1, pipe2;
    logic [16*DW-1:0] bf_tw;
    logic bypass = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int x_re[16];
    int x_im[16];
    logic [31:0] got[16];
    logic [15:0] got_last;
    logic [31:0] cap0[4];
    logic [31:0] cap1[4];
    logic [31:0] captw[4][8];
    int cc;
    logic stable_bf, stable_out, ready_low_ok;
    int ord[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;

    fft16_stage_sequencer #(.DATA_W(DW), .BF_LAT(LAT), .TW_FRAC(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .bf_in(bf_in), .bf_tw(bf_tw), .bf_out(bf_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_last(out_last), .busy(busy)
    );

    // Butterfly model: top = a + W*b, bot = a - W*b, with the product in Q1.14.
    function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] w);
        int ar, ai, br, bi, wr, wi, tr, ti;
        ar = int'($signed(a[15:0])); ai = int'($signed(a[31:16]));
        br = int'($signed(b[15:0])); bi = int'($signed(b[31:16]));
        wr = int'($signed(w[15:0])); wi = int'($signed(w[31:16]));
        tr = (wr * br - wi * bi) >>> 14;
        ti = (wr * bi + wi * br) >>> 14;
        return {16'(ai - ti), 16'(ar - tr), 16'(ai + ti), 16'(ar + tr)};
    endfunction

    always_comb begin
        bf_comb = '0;
        for (int b = 0; b < 8; b++)
            bf_comb[b*64 +: 64] = bypass ? bf_in[b*64 +: 64]
                                         : bfly(bf_in[b*64 +: 32], bf_in[b*64+32 +: 32],
                                                bf_tw[b*32 +: 32]);
    end

    always @(posedge clk) begin
        pipe1 <= bf_comb;
        pipe2 <= pipe1;
    end
    assign bf_out = pipe2;

    function automatic logic [31:0] cpx(input int re, input int im);
        return {16'(im), 16'(re)};
    endfunction

    function automatic int sc(input int v, input int s);
        return v >>> (SCALE_ON ? s : 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load_frame(input bit gaps);
        int n = 0;
        int guard = 0;
        @(negedge clk);
        chk("load_ready", 64'(in_ready), 64'd1);
        chk("load_idle", 64'({busy, out_valid}), 64'd0);
        while (n < 16 && guard < 200) begin
            in_valid = (n == 0) || !gaps || ($urandom_range(0, 2) != 0);
            in_real  = DW'(x_re[n]);
            in_imag  = DW'(x_im[n]);
            if (in_valid && in_ready) n++;
            guard++;
            if (n < 16) @(negedge clk);
        end
        if (n < 16) chk("load_timeout", 64'(n), 64'd16);
    endtask

    // Track the compute phase. It returns early after abort_at cycles if
    // abort_at is nonzero.
    task automatic compute_watch(input int abort_at);
        int guard = 0;
        int s;
        cc = 0;
        stable_bf = 1'b1;
        @(negedge clk);
        while (busy && !out_valid && guard < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            in_real  = 16'h7fff;
            in_imag  = 16'h7fff;
            if (in_ready) ready_low_ok = 1'b0;
            s = cc / (LAT + 1);
            if (s < 4) begin
                if (cc % (LAT + 1) == 0) begin
                    cap0[s] = bf_in[31:0];
                    cap1[s] = bf_in[63:32];
                    for (int b = 0; b < 8; b++) captw[s][b] = bf_tw[b*32 +: 32];
                end else if (bf_in[63:0] != {cap1[s], cap0[s]}) begin
                    stable_bf = 1'b0;
                end
            end
            cc++;
            guard++;
            if (cc == abort_at) return;
            @(negedge clk);
        end
    endtask

    task automatic unload_frame(input bit stalls);
        int u = 0;
        int guard = 0;
        logic [31:0] prev = '0;
        logic prev_stall = 1'b0;
        got_last   = '0;
        stable_out = 1'b1;
        while (u < 16 && guard < 300) begin
            if (out_valid) begin
                if (in_ready) ready_low_ok = 1'b0;
                if (prev_stall && {out_imag, out_real} != prev) stable_out = 1'b0;
                out_ready  = !stalls || ($urandom_range(0, 2) != 0);
                prev       = {out_imag, out_real};
                prev_stall = !out_ready;
                if (out_ready) begin
                    got[u]      = prev;
                    got_last[u] = out_last;
                    u++;
                end
            end
            in_valid = (u < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            guard++;
            if (u < 16) @(negedge clk);
        end
        if (u < 16) chk("unload_timeout", 64'(u), 64'd16);
    endtask

    task automatic check_impulse(input string tag);
        for (int u = 0; u < 16; u++)
            chk($sformatf("%s_bin%0d", tag, u), 64'(got[u]), 64'(cpx(SCALE_ON ? 6 : 100, 0)));
    endtask

    initial begin
        ready_low_ok = 1'b1;
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_bf_zero", 64'((bf_in != '0) || (bf_tw != '0)), 64'd0);
        rst = 1'b0;

        // Impulse, no gaps or stalls
        for (int n = 0; n < 16; n++) begin x_re[n] = (n == 0) ? 100 : 0; x_im[n] = 0; end
        bypass = 1'b0; out_ready = 1'b1;
        load_frame(1'b0);
        compute_watch(0);
        chk("imp_compute_cycles", 64'(cc), 64'd12);
        chk("imp_bf_stable", 64'(stable_bf), 64'd1);
        unload_frame(1'b0);
        check_impulse("imp");

        // DC, back-to-back, with input gaps and output stalls
        for (int n = 0; n < 16; n++) begin x_re[n] = 64; x_im[n] = 0; end
        load_frame(1'b1);
        compute_watch(0);
        chk("dc_compute_cycles", 64'(cc), 64'd12);
        unload_frame(1'b1);
        chk("dc_out_stable", 64'(stable_out), 64'd1);
        chk("dc_last_only15", 64'(got_last), 64'h8000);
        for (int u = 0; u < 16; u++)
            chk($sformatf("dc_bin%0d", u), 64'(got[u]),
                64'(cpx((u == 0) ? (SCALE_ON ? 64 : 1024) : 0, 0)));

        // Routing with a passthrough butterfly model, ramp x[n] = n
        for (int n = 0; n < 16; n++) begin x_re[n] = n; x_im[n] = 0; end
        bypass = 1'b1;
        load_frame(1'b0);
        compute_watch(0);
        chk("rt_s0_e0", 64'(cap0[0]), 64'(cpx(0, 0)));
        chk("rt_s0_e1", 64'(cap1[0]), 64'(cpx(8, 0)));
        chk("rt_s1_e1", 64'(cap1[1]), 64'(cpx(sc(4, 1), 0)));
        chk("rt_s2_e1", 64'(cap1[2]), 64'(cpx(sc(2, 2), 0)));
        chk("rt_s3_e0", 64'(cap0[3]), 64'(cpx(0, 0)));
        chk("rt_s3_e1", 64'(cap1[3]), 64'(cpx(sc(1, 3), 0)));
        chk("tw_s0_b6", 64'(captw[0][6]), 64'(cpx(16384, 0)));
        chk("tw_s1_b1", 64'(captw[1][1]), 64'(cpx(0, -16384)));
        chk("tw_s2_b3", 64'(captw[2][3]), 64'(cpx(-11585, -11585)));
        chk("tw_s3_b1", 64'(captw[3][1]), 64'(cpx(15137, -6270)));
        chk("tw_s3_b5", 64'(captw[3][5]), 64'(cpx(-6270, -15137)));
        chk("tw_s3_b7", 64'(captw[3][7]), 64'(cpx(-15137, -6270)));
        unload_frame(1'b1);
        for (int u = 0; u < 16; u++)
            chk($sformatf("rt_out%0d", u), 64'(got[u]), 64'(cpx(sc(ord[u], 4), 0)));

        // Reset during stage 2, then run a fresh impulse frame
        bypass = 1'b0;
        load_frame(1'b1);
        compute_watch(7);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_bf_zero", 64'(bf_in != '0), 64'd0);
        for (int n = 0; n < 16; n++) begin x_re[n] = (n == 0) ? 100 : 0; x_im[n] = 0; end
        load_frame(1'b0);
        compute_watch(0);
        chk("abort_compute_cycles", 64'(cc), 64'd12);
        unload_frame(1'b0);
        check_impulse("post_abort");

        chk("in_ready_low_busy", 64'(ready_low_ok), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft16_stage_sequencer.md
Name: fft16_stage_sequencer

Overview:
- Controller for the 16-point radix-2 DIT FFT built on `butterfly_block`, which holds 8 parallel 16-bit complex butterflies.
- Accepts 16 complex samples on a streaming input and stores them in bit-reversed order in an internal 16-entry register file.
- Runs 4 stages by routing register-file pairs and twiddles to `butterfly_block`, then writing the results back.
- Streams the 16 frequency bins out in natural order. Sits between the sample source and the downstream spectrum consumer.

Parameters:
- DATA_W, 16: width of each real and imaginary component, two's complement.
- BF_LAT, 0: pipeline latency of the attached `butterfly_block` in cycles (0 = combinational).
- TW_FRAC, 14: fractional bits of the twiddle constants (Q1.14).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_real  in  DATA_W  input sample, real part.
- in_imag  in  DATA_W  input sample, imaginary part.
- bf_in  out  32*DATA_W  16 complex operands to `butterfly_block`. Element e occupies bits [(2e+1)*DATA_W-1 : 2e*DATA_W] for the real part, followed by the imaginary part.
- bf_tw  out  16*DATA_W  8 complex twiddles, one per butterfly, same packing.
- bf_out  in  32*DATA_W  16 complex results from `butterfly_block`, same packing.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the bin.
- out_real  out  DATA_W  output bin, real part.
- out_imag  out  DATA_W  output bin, imaginary part.
- out_last  out  1  marks bin 15.
- busy  out  1  high in COMPUTE and UNLOAD.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_last=0, busy=0, all counters 0. bf_in and bf_tw are driven to 0 outside COMPUTE. The register file is not cleared.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, sample n (n = load counter 0..15) is written to mem[bitrev4(n)], e.g. n=1 goes to mem[8], n=3 goes to mem[12].
  - After the handshake with n=15: go to COMPUTE with stage s=0 and wait counter w=0; in_ready drops in the next cycle.
- COMPUTE:
  - in_ready=0, busy=1.
  - For stage s, let h=2^s. For butterfly b (0..7): p=b&(h-1), top=((b>>s)<<(s+1))+p, bot=top+h.
  - bf_in element 2b = mem[top]; element 2b+1 = mem[bot].
  - bf_tw element b = W16^k with k=p*(8>>s).
  - bf_in and bf_tw are registered and held stable for BF_LAT+1 cycles.
  - When w==BF_LAT, bf_out element 2b is written to mem[top] and element 2b+1 to mem[bot]. Then w clears and s increments.
  - After the write-back of s=3, go to UNLOAD. Compute takes exactly 4*(BF_LAT+1) cycles.
- Twiddle ROM (Q1.14, real/imag), indexed by k:
  - k0: 16384, 0
  - k1: 15137, -6270
  - k2: 11585, -11585
  - k3: 6270, -15137
  - k4: 0, -16384
  - k5: -6270, -15137
  - k6: -11585, -11585
  - k7: -15137, -6270
- UNLOAD:
  - out_valid=1; out_real/out_imag = mem[u] for u = 0..15, in natural order; out_last=(u==15).
  - u advances only on out_valid&&out_ready. Data is held stable while out_ready=0.
  - After the handshake with u=15: go to LOAD with in_ready=1 and out_valid=0 in the next cycle.
  - Output is not overlapped with the next load (no ping-pong).
- Arithmetic: the sequencer performs no arithmetic and does not saturate. Overflow behaviour belongs to `butterfly_block`, except under the optional feature below.
- Boundary conditions:
  - in_valid during COMPUTE or UNLOAD is ignored; no sample is lost because in_ready=0.
  - rst asserted in any state, including mid-COMPUTE or mid-UNLOAD, aborts the frame. State returns to LOAD the next cycle and the partial frame is discarded.
  - Back-to-back frames: the first sample of a new frame may be accepted in the cycle immediately after the last output handshake.

Optional Feature:
- Macro: FFT_STAGE_SCALE_EN.
- When defined: each write-back stores every real and imaginary result arithmetically shifted right by 1 (floor). Output is X/16, so the frame cannot overflow for in-range input.
- When undefined: results are written back unmodified.

Test Plan:
- Impulse: load x[0]=100+0j, x[1..15]=0, BF_LAT=0, out_ready=1 -> all 16 bins = 100+0j with the macro off; with FFT_STAGE_SCALE_EN, all bins = 6+0j (100->50->25->12->6).
- DC: all x[n]=64+0j -> bin 0 = 1024+0j and bins 1..15 = 0 with the macro off; 64+0j and 0 with the macro on. out_last is high only on bin 15.
- Bit-reverse and routing: load x[n]=n+0j with a `butterfly_block` stub that passes inputs through (out=in). Check bf_in pairings per stage, e.g. stage 0 element 0/1 = 0/8 and stage 3 element 0/1 = mem[0]/mem[8]. Check the twiddle index per butterfly (stage 3: k=b) and the passthrough output order 0,8,4,12,2,...
- Handshake and latency: BF_LAT=2 with random in_valid gaps and out_ready stalls -> compute lasts 12 cycles, output data is stable during stalls, no lost or duplicated bins, and in_ready=0 throughout COMPUTE/UNLOAD.
- Reset mid-frame: assert rst during stage 2 of COMPUTE, then load a fresh impulse frame -> next cycle in_ready=1, busy=0, out_valid=0, and the outputs match the impulse result.
